proc_control_fsm: RTL and testbench

//  Multi-cycle control unit; drives the program counter (increment/load), IR, register file and memory.

---
 rtl/proc_control_fsm_pkg.sv | 37 +++
 rtl/proc_control_fsm_instr_decoder.sv | 25 ++
 rtl/proc_control_fsm.sv | 181 ++++++++++++++++++
 tb/tb_proc_control_fsm.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/proc_control_fsm_pkg.sv
// Shared definitions for the multi-cycle control unit: widths, opcodes,
// bus-select codes and the controller state encoding.
package proc_control_fsm_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_JNZ = 3'b110;
  localparam logic [2:0] OP_J   = 3'b111;

  localparam logic [3:0] BUS_G   = 4'd8;
  localparam logic [3:0] BUS_MEM = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_EX1    = 3'd4,
    S_EX2    = 3'd5,
    S_EX3    = 3'd6
  } state_e;

  // One-hot write enable for a 3-bit register index.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [2:0] idx);
    logic [NREGS-1:0] one;
    one = {{(NREGS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/proc_control_fsm_instr_decoder.sv
// Combinational instruction field decode: opcode one-hot, register fields
// and the one-hot register write enable for Rx.
module instr_decoder
  import proc_control_fsm_pkg::*;
(
  input  logic [DATA_W-1:0] ir_i,
  output logic [7:0]        op_oh_o,
  output logic [2:0]        rx_o,
  output logic [2:0]        ry_o,
  output logic [NREGS-1:0]  rx_oh_o
);

  // The low seven instruction bits carry no meaning for this machine.
  logic unused_ir_low;
  assign unused_ir_low = ^ir_i[6:0];

  // Field extraction and one-hot expansion.
  always_comb begin
    op_oh_o = 8'b0000_0001 << ir_i[15:13];
    rx_o    = ir_i[12:10];
    ry_o    = ir_i[9:7];
    rx_oh_o = reg_onehot(ir_i[12:10]);
  end

endmodule

// File: rtl/proc_control_fsm.sv
// Multi-cycle control unit: fetch, memory wait, decode, then one to three
// execute steps per instruction, driving PC, IR, register file and memory.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | nothing driven, waiting for p_Run
//   S_FETCH  | PC presented to memory, PC incremented
//   S_WAIT   | registered RAM latency cycle
//   S_DECODE | instruction word valid on p_MemData, captured into IR
//   S_EX1    | first execute step (single-step ops finish here)
//   S_EX2    | second execute step (st finishes here)
//   S_EX3    | third execute step (mvi/add/sub/ld finish here)
module proc_control_fsm
  import proc_control_fsm_pkg::*;
(
  input  logic              p_Clock,
  input  logic              p_Reset,
  input  logic              p_Run,
  input  logic [DATA_W-1:0] p_MemData,
  input  logic              p_Zero,
  output logic              p_IncPC,
  output logic              p_LoadPC,
  output logic              p_LoadIR,
  output logic              p_AddrSel,
  output logic              p_LoadAddr,
  output logic              p_MemWrite,
  output logic [3:0]        p_BusSel,
  output logic [NREGS-1:0]  p_RegIn,
  output logic              p_LoadA,
  output logic              p_LoadG,
  output logic              p_AluOp,
  output logic              p_Done
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  logic [7:0]        op_oh;
  logic [2:0]        rx, ry;
  logic [NREGS-1:0]  rx_oh;

  instr_decoder u_dec (
    .ir_i    (ir_q),
    .op_oh_o (op_oh),
    .rx_o    (rx),
    .ry_o    (ry),
    .rx_oh_o (rx_oh)
  );

  // State and instruction register, synchronous active-high reset.
  always_ff @(posedge p_Clock) begin
    if (p_Reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state and output decode; reset forces every output low so a
  // half-finished instruction cannot complete a write.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    p_IncPC    = 1'b0;
    p_LoadPC   = 1'b0;
    p_LoadIR   = 1'b0;
    p_AddrSel  = 1'b0;
    p_LoadAddr = 1'b0;
    p_MemWrite = 1'b0;
    p_BusSel   = 4'd0;
    p_RegIn    = '0;
    p_LoadA    = 1'b0;
    p_LoadG    = 1'b0;
    p_AluOp    = 1'b0;
    p_Done     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (p_Run) state_d = S_FETCH;
      end
      S_FETCH: begin
        p_AddrSel = 1'b0;
        p_IncPC   = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        p_AddrSel = 1'b0;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        p_LoadIR = 1'b1;
        ir_d     = p_MemData;
        state_d  = S_EX1;
      end
      S_EX1: begin
        state_d = S_EX2;
        if (op_oh[OP_MV]) begin
          p_BusSel = {1'b0, ry};
          p_RegIn  = rx_oh;
          p_Done   = 1'b1;
        end else if (op_oh[OP_MVI]) begin
          p_AddrSel = 1'b0;
          p_IncPC   = 1'b1;
        end else if (op_oh[OP_ADD] || op_oh[OP_SUB]) begin
          p_BusSel = {1'b0, rx};
          p_LoadA  = 1'b1;
        end else if (op_oh[OP_LD] || op_oh[OP_ST]) begin
          p_BusSel   = {1'b0, ry};
          p_LoadAddr = 1'b1;
        end else if (op_oh[OP_JNZ]) begin
          // Only the jump itself depends on the flag; completion does not.
          if (!p_Zero) begin
            p_BusSel = {1'b0, ry};
            p_LoadPC = 1'b1;
          end
          p_Done = 1'b1;
        end else begin
          p_BusSel = {1'b0, ry};
          p_LoadPC = 1'b1;
          p_Done   = 1'b1;
        end
      end
      S_EX2: begin
        state_d = S_EX3;
        if (op_oh[OP_ADD] || op_oh[OP_SUB]) begin
          p_BusSel = {1'b0, ry};
          p_LoadG  = 1'b1;
          p_AluOp  = op_oh[OP_SUB];
        end else if (op_oh[OP_LD]) begin
          p_AddrSel = 1'b1;
        end else if (op_oh[OP_ST]) begin
          p_AddrSel  = 1'b1;
          p_BusSel   = {1'b0, rx};
          p_MemWrite = 1'b1;
          p_Done     = 1'b1;
        end else if (!op_oh[OP_MVI]) begin
          state_d = S_IDLE;
        end
      end
      S_EX3: begin
        state_d = S_IDLE;
        if (op_oh[OP_MVI]) begin
          p_BusSel = BUS_MEM;
          p_RegIn  = rx_oh;
          p_Done   = 1'b1;
        end else if (op_oh[OP_ADD] || op_oh[OP_SUB]) begin
          p_BusSel = BUS_G;
          p_RegIn  = rx_oh;
          p_Done   = 1'b1;
        end else if (op_oh[OP_LD]) begin
          p_AddrSel = 1'b1;
          p_BusSel  = BUS_MEM;
          p_RegIn   = rx_oh;
          p_Done    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // p_Run is only looked at here and in IDLE.
    if (p_Done) state_d = p_Run ? S_FETCH : S_IDLE;

    if (p_Reset) begin
      p_IncPC    = 1'b0;
      p_LoadPC   = 1'b0;
      p_LoadIR   = 1'b0;
      p_AddrSel  = 1'b0;
      p_LoadAddr = 1'b0;
      p_MemWrite = 1'b0;
      p_BusSel   = 4'd0;
      p_RegIn    = '0;
      p_LoadA    = 1'b0;
      p_LoadG    = 1'b0;
      p_AluOp    = 1'b0;
      p_Done     = 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed bench for proc_control_fsm: every cycle of each instruction is
// compared against a hand-written output vector.
module tb_proc_control_fsm;
  import proc_control_fsm_pkg::*;

  logic        p_Clock;
  logic        p_Reset;
  logic        p_Run;
  logic [15:0] p_MemData;
  logic        p_Zero;
  logic        p_IncPC, p_LoadPC, p_LoadIR, p_AddrSel, p_LoadAddr, p_MemWrite;
  logic [3:0]  p_BusSel;
  logic [7:0]  p_RegIn;
  logic        p_LoadA, p_LoadG, p_AluOp, p_Done;

  int n_checks = 0;
  int n_pass   = 0;

  proc_control_fsm dut (
    .p_Clock    (p_Clock),
    .p_Reset    (p_Reset),
    .p_Run      (p_Run),
    .p_MemData  (p_MemData),
    .p_Zero     (p_Zero),
    .p_IncPC    (p_IncPC),
    .p_LoadPC   (p_LoadPC),
    .p_LoadIR   (p_LoadIR),
    .p_AddrSel  (p_AddrSel),
    .p_LoadAddr (p_LoadAddr),
    .p_MemWrite (p_MemWrite),
    .p_BusSel   (p_BusSel),
    .p_RegIn    (p_RegIn),
    .p_LoadA    (p_LoadA),
    .p_LoadG    (p_LoadG),
    .p_AluOp    (p_AluOp),
    .p_Done     (p_Done)
  );

  initial p_Clock = 1'b0;
  always #5 p_Clock = ~p_Clock;

  logic [21:0] obs;
  assign obs = {p_IncPC, p_LoadPC, p_LoadIR, p_AddrSel, p_LoadAddr, p_MemWrite,
                p_BusSel, p_RegIn, p_LoadA, p_LoadG, p_AluOp, p_Done};

  // Expected output vector in the same packing as obs.
  function automatic logic [21:0] mk(input bit inc, input bit lpc, input bit lir,
                                     input bit asel, input bit laddr, input bit mw,
                                     input logic [3:0] bus, input logic [7:0] rin,
                                     input bit la, input bit lg, input bit op,
                                     input bit dn);
    return {inc, lpc, lir, asel, laddr, mw, bus, rin, la, lg, op, dn};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Compare outputs mid-cycle, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [21:0] exp);
    #1;
    check(tag, {10'd0, obs}, {10'd0, exp});
    @(posedge p_Clock);
    #1;
  endtask

  task automatic fetch(input string tag);
    cyc({tag, "_fetch"},  mk(1,0,0,0,0,0, 4'd0, 8'h00, 0,0,0,0));
    cyc({tag, "_wait"},   mk(0,0,0,0,0,0, 4'd0, 8'h00, 0,0,0,0));
    cyc({tag, "_decode"}, mk(0,0,1,0,0,0, 4'd0, 8'h00, 0,0,0,0));
  endtask

  initial begin
    p_Reset   = 1'b1;
    p_Run     = 1'b1;
    p_MemData = 16'h0000;
    p_Zero    = 1'b0;

    // Reset held two cycles with p_Run high.
    cyc("rst_c0", 22'd0);
    check("rst_state0", 32'(dut.state_q), 32'(S_IDLE));
    cyc("rst_c1", 22'd0);
    check("rst_state1", 32'(dut.state_q), 32'(S_IDLE));
    check("rst_ir", 32'(dut.ir_q), 32'd0);

    // Release: one IDLE cycle, then FETCH.
    p_Reset   = 1'b0;
    p_MemData = 16'h0A80;                       // mv R2,R5
    cyc("rel_idle", 22'd0);
    fetch("mv");
    cyc("mv_ex1",   mk(0,0,0,0,0,0, 4'd5, 8'h04, 0,0,0,1));

    p_MemData = 16'h2400;                       // mvi R1
    fetch("mvi");
    p_MemData = 16'h1234;
    cyc("mvi_ex1",  mk(1,0,0,0,0,0, 4'd0, 8'h00, 0,0,0,0));
    cyc("mvi_ex2",  mk(0,0,0,0,0,0, 4'd0, 8'h00, 0,0,0,0));
    cyc("mvi_ex3",  mk(0,0,0,0,0,0, 4'd9, 8'h02, 0,0,0,1));

    // sub R3,R4 with p_Run dropped mid-instruction.
    p_MemData = 16'h6E00;
    fetch("sub");
    cyc("sub_ex1",  mk(0,0,0,0,0,0, 4'd3, 8'h00, 1,0,0,0));
    p_Run = 1'b0;
    cyc("sub_ex2",  mk(0,0,0,0,0,0, 4'd4, 8'h00, 0,1,1,0));
    cyc("sub_ex3",  mk(0,0,0,0,0,0, 4'd8, 8'h08, 0,0,0,1));
    check("sub_to_idle", 32'(dut.state_q), 32'(S_IDLE));
    cyc("idle_hold", 22'd0);
    check("idle_stays", 32'(dut.state_q), 32'(S_IDLE));

    // jnz R6, both flag values.
    p_Run     = 1'b1;
    p_MemData = 16'hC300;
    p_Zero    = 1'b0;
    cyc("idle_go", 22'd0);
    fetch("jnz0");
    cyc("jnz0_ex1", mk(0,1,0,0,0,0, 4'd6, 8'h00, 0,0,0,1));
    p_Zero = 1'b1;
    fetch("jnz1");
    cyc("jnz1_ex1", mk(0,0,0,0,0,0, 4'd0, 8'h00, 0,0,0,1));
    p_Zero = 1'b0;

    p_MemData = 16'hE180;                       // j R3
    fetch("j");
    cyc("j_ex1",    mk(0,1,0,0,0,0, 4'd3, 8'h00, 0,0,0,1));

    p_MemData = 16'hA780;                       // st R1,[R7]
    fetch("st");
    cyc("st_ex1",   mk(0,0,0,0,1,0, 4'd7, 8'h00, 0,0,0,0));
    cyc("st_ex2",   mk(0,0,0,1,0,1, 4'd1, 8'h00, 0,0,0,1));

    p_MemData = 16'h9500;                       // ld R5,[R2]
    fetch("ld");
    cyc("ld_ex1",   mk(0,0,0,0,1,0, 4'd2, 8'h00, 0,0,0,0));
    cyc("ld_ex2",   mk(0,0,0,1,0,0, 4'd0, 8'h00, 0,0,0,0));
    cyc("ld_ex3",   mk(0,0,0,1,0,0, 4'd9, 8'h20, 0,0,0,1));

    // Same ld, reset asserted in EX2: no register write may follow.
    fetch("ldr");
    cyc("ldr_ex1",  mk(0,0,0,0,1,0, 4'd2, 8'h00, 0,0,0,0));
    p_Reset = 1'b1;
    p_Run   = 1'b0;
    cyc("ldr_ex2_rst", 22'd0);
    p_Reset = 1'b0;
    check("ldr_state", 32'(dut.state_q), 32'(S_IDLE));
    check("ldr_ir", 32'(dut.ir_q), 32'd0);
    cyc("ldr_after", 22'd0);
    check("ldr_idle", 32'(dut.state_q), 32'(S_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
